// File: rtl/sopc_ctrl_pkg.sv
// sopc_ctrl_pkg: controller state encoding, reset cause codes and domain release helper.
package sopc_ctrl_pkg;

    typedef enum logic [1:0] {ST_RESET, ST_HOLD, ST_RUN, ST_HALT} state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_SOFT = 2'b01;
    localparam logic [1:0] CAUSE_WDT  = 2'b10;

    function automatic int unsigned release_at(int unsigned hold_cyc, int unsigned stagger,
                                               int unsigned dom);
        return hold_cyc + dom * stagger;
    endfunction

endpackage

// File: rtl/sopc_rst_sync.sv
// sopc_rst_sync: 2-flop synchroniser for the board reset, asserts asynchronously and
// releases on the second clock edge after rst rises.
module sopc_rst_sync (
    input  logic clk,
    input  logic rst,
    output logic rst_sync
);

    logic [1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= '0;
        else      ff <= {ff[0], 1'b1};
    end

    assign rst_sync = ff[1];

endmodule

// File: rtl/sopc_rst_run_ctrl.sv
// sopc_rst_run_ctrl: staggered domain reset sequencer and run-limit controller.
// Define SOPC_WDT_EN to add the run-time watchdog (timeout WDT_CYC cycles).
module sopc_rst_run_ctrl
    import sopc_ctrl_pkg::*;
#(
    parameter int unsigned N_DOM     = 2,
    parameter int unsigned HOLD_CYC  = 10,
    parameter int unsigned STAGGER   = 2,
    parameter int unsigned RUN_LIMIT = 25,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned WDT_CYC   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst_req,
    input  logic             resume,
    input  logic             wdt_kick,
    output logic [N_DOM-1:0] dom_rst,
    output logic             clk_en,
    output logic [CNT_W-1:0] run_cnt,
    output logic             halted,
    output logic [1:0]       rst_cause
);

    localparam int unsigned LAST  = release_at(HOLD_CYC, STAGGER, N_DOM - 1);
    localparam int unsigned SEQ_W = $clog2(LAST + 1);

    logic             rst_sync;
    logic             wdt_hit;
    state_t           state, state_nx, cur;
    logic [SEQ_W-1:0] seq_cnt, seq_nx;
    logic [CNT_W-1:0] run_nx;
    logic [1:0]       cause_nx;

    sopc_rst_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .rst_sync (rst_sync)
    );

`ifdef SOPC_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYC + 1);

    logic [WDT_W-1:0] wdt_cnt, wdt_nx;

    assign wdt_hit = (cur == ST_RUN || cur == ST_HALT) && wdt_cnt == WDT_W'(WDT_CYC - 1);

    always_comb begin
        wdt_nx = (cur == ST_RUN) ? (wdt_kick ? '0 : wdt_cnt + 1'b1) : wdt_cnt;
        if (wdt_hit || (soft_rst_req && cur != ST_RESET)) wdt_nx = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wdt_cnt <= '0;
        else      wdt_cnt <= wdt_nx;
    end
`else
    logic unused_wdt;

    assign unused_wdt = wdt_kick ^ (WDT_CYC == 0);
    assign wdt_hit    = 1'b0;
`endif

    // The first synchronised cycle already behaves as HOLD with seq_cnt = 0.
    always_comb begin
        cur      = (state == ST_RESET && rst_sync) ? ST_HOLD : state;
        state_nx = cur;
        seq_nx   = seq_cnt;
        run_nx   = run_cnt;
        cause_nx = rst_cause;
        if (cur != ST_RESET && (soft_rst_req || wdt_hit)) begin
            state_nx = ST_HOLD;
            seq_nx   = '0;
            run_nx   = '0;
            cause_nx = soft_rst_req ? CAUSE_SOFT : CAUSE_WDT;
        end else if (cur == ST_HOLD) begin
            if (seq_cnt == SEQ_W'(LAST)) state_nx = ST_RUN;
            else                         seq_nx   = seq_cnt + 1'b1;
        end else if (cur == ST_RUN) begin
            if (RUN_LIMIT != 0 && run_cnt == CNT_W'(RUN_LIMIT)) state_nx = ST_HALT;
            else if (run_cnt != '1)                             run_nx   = run_cnt + 1'b1;
        end else if (cur == ST_HALT && resume) begin
            state_nx = ST_RUN;
            run_nx   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RESET;
            seq_cnt   <= '0;
            run_cnt   <= '0;
            rst_cause <= CAUSE_POR;
        end else begin
            state     <= state_nx;
            seq_cnt   <= seq_nx;
            run_cnt   <= run_nx;
            rst_cause <= cause_nx;
        end
    end

    for (genvar d = 0; d < N_DOM; d++) begin : g_dom
        localparam logic [SEQ_W-1:0] THR = SEQ_W'(release_at(HOLD_CYC, STAGGER, d));
        assign dom_rst[d] = (cur == ST_RESET) || (cur == ST_HOLD && seq_cnt < THR);
    end

    assign clk_en = cur != ST_HALT;
    assign halted = cur == ST_HALT;

endmodule

// File: tb/tb_sopc_rst_run_ctrl.sv
// tb_sopc_rst_run_ctrl: directed scenarios plus randomized traffic against a phase/age
// reference model of the reset sequencer and run controller.
module tb_sopc_rst_run_ctrl;

    localparam int N_DOM     = 2;
    localparam int HOLD_CYC  = 10;
    localparam int STAGGER   = 2;
    localparam int RUN_LIMIT = 25;
    localparam int CNT_W     = 32;
    localparam int WDT_CYC   = 16;
`ifdef SOPC_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif
    localparam int M_RESET = 0, M_SEQ = 1, M_RUN = 2, M_HALT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             soft_rst_req = 1'b0;
    logic             resume = 1'b0;
    logic             wdt_kick = 1'b0;
    logic [N_DOM-1:0] dom_rst;
    logic             clk_en;
    logic [CNT_W-1:0] run_cnt;
    logic             halted;
    logic [1:0]       rst_cause;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase, cycles since sequence start, run cycles, cause, watchdog age.
    int m_mode = M_RESET, m_edges = 0, m_age = 0, m_runs = 0, m_cause = 0, m_wdt = 0;

    always #10 clk = ~clk;

    sopc_rst_run_ctrl #(
        .N_DOM(N_DOM), .HOLD_CYC(HOLD_CYC), .STAGGER(STAGGER),
        .RUN_LIMIT(RUN_LIMIT), .CNT_W(CNT_W), .WDT_CYC(WDT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .resume       (resume),
        .wdt_kick     (wdt_kick),
        .dom_rst      (dom_rst),
        .clk_en       (clk_en),
        .run_cnt      (run_cnt),
        .halted       (halted),
        .rst_cause    (rst_cause)
    );

    function automatic logic [N_DOM-1:0] exp_dom();
        logic [N_DOM-1:0] v;
        for (int d = 0; d < N_DOM; d++)
            v[d] = (m_mode == M_RESET) || (m_mode == M_SEQ && m_age < HOLD_CYC + d * STAGGER);
        return v;
    endfunction

    task automatic model_rst();
        m_mode = M_RESET; m_edges = 0; m_age = 0; m_runs = 0; m_cause = 0; m_wdt = 0;
    endtask

    task automatic model_edge();
        if (!rst) return;
        if (m_mode == M_RESET) begin
            m_edges++;
            if (m_edges == 2) begin m_mode = M_SEQ; m_age = 0; end
        end else if (soft_rst_req || (WDT_ON && m_mode >= M_RUN && m_wdt == WDT_CYC - 1)) begin
            m_cause = soft_rst_req ? 1 : 2;
            m_mode = M_SEQ; m_age = 0; m_runs = 0; m_wdt = 0;
        end else if (m_mode == M_SEQ) begin
            if (m_age == HOLD_CYC + (N_DOM - 1) * STAGGER) m_mode = M_RUN;
            else m_age++;
        end else if (m_mode == M_RUN) begin
            m_wdt = wdt_kick ? 0 : m_wdt + 1;
            if (RUN_LIMIT != 0 && m_runs == RUN_LIMIT) m_mode = M_HALT;
            else m_runs++;
        end else if (resume) begin
            m_mode = M_RUN; m_runs = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #100;
        n_cmp++; if (dom_rst !== 2'b11) begin n_bad++; $display("FAIL reset_dom_rst: got %b want 11", dom_rst); end
        n_cmp++; if (clk_en !== 1'b1) begin n_bad++; $display("FAIL reset_clk_en: got %b want 1", clk_en); end
        n_cmp++; if (run_cnt !== '0) begin n_bad++; $display("FAIL reset_run_cnt: got %0d want 0", run_cnt); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (rst_cause !== 2'b00) begin n_bad++; $display("FAIL reset_cause: got %b want 00", rst_cause); end
        #95;
        rst = 1'b1;
    endtask

    task automatic test_por();
        int f0 = -1, f1 = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            n_cmp++;
            if (dom_rst !== exp_dom()) begin n_bad++; $display("FAIL por_dom_rst: edge %0d got %b want %b", k, dom_rst, exp_dom()); end
            if (f0 < 0 && dom_rst[0] === 1'b0) f0 = k;
            if (f1 < 0 && dom_rst[1] === 1'b0) f1 = k;
        end
        n_cmp++; if (f0 !== 2 + HOLD_CYC) begin n_bad++; $display("FAIL por_dom0_edge: got %0d want %0d", f0, 2 + HOLD_CYC); end
        n_cmp++; if (f1 !== 2 + HOLD_CYC + STAGGER) begin n_bad++; $display("FAIL por_dom1_edge: got %0d want %0d", f1, 2 + HOLD_CYC + STAGGER); end
        n_cmp++; if (rst_cause !== 2'b00) begin n_bad++; $display("FAIL por_cause: got %b want 00", rst_cause); end
    endtask

    task automatic test_run_limit();
        wdt_kick = 1'b1;
        for (int k = 0; k < 100 && halted !== 1'b1; k++) begin
            tick();
            n_cmp++;
            if (run_cnt !== CNT_W'(m_runs) || halted !== (m_mode == M_HALT)) begin
                n_bad++; $display("FAIL limit_track: got cnt=%0d halted=%b want cnt=%0d halted=%b", run_cnt, halted, m_runs, m_mode == M_HALT);
            end
        end
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL limit_halted: got %b want 1", halted); end
        n_cmp++; if (clk_en !== 1'b0) begin n_bad++; $display("FAIL limit_clk_en: got %b want 0", clk_en); end
        n_cmp++; if (run_cnt !== RUN_LIMIT) begin n_bad++; $display("FAIL limit_cnt: got %0d want %0d", run_cnt, RUN_LIMIT); end
        repeat (3) tick();
        n_cmp++; if (run_cnt !== RUN_LIMIT) begin n_bad++; $display("FAIL limit_cnt_hold: got %0d want %0d", run_cnt, RUN_LIMIT); end
    endtask

    task automatic test_resume();
        int n = 0;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        n_cmp++; if (run_cnt !== '0) begin n_bad++; $display("FAIL resume_cnt: got %0d want 0", run_cnt); end
        n_cmp++; if (clk_en !== 1'b1 || halted !== 1'b0) begin n_bad++; $display("FAIL resume_run: got clk_en=%b halted=%b want 1 0", clk_en, halted); end
        for (int k = 0; k < 100 && halted !== 1'b1; k++) begin tick(); n++; end
        n_cmp++; if (n !== RUN_LIMIT + 1) begin n_bad++; $display("FAIL resume_rehalt: got %0d cycles want %0d", n, RUN_LIMIT + 1); end
    endtask

    task automatic test_soft_rst();
        int f0 = -1, f1 = -1;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        for (int k = 0; k < 50 && run_cnt !== 7; k++) tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        n_cmp++; if (dom_rst !== 2'b11) begin n_bad++; $display("FAIL soft_dom_rst: got %b want 11", dom_rst); end
        n_cmp++; if (rst_cause !== 2'b01) begin n_bad++; $display("FAIL soft_cause: got %b want 01", rst_cause); end
        n_cmp++; if (run_cnt !== '0 || halted !== 1'b0) begin n_bad++; $display("FAIL soft_clear: got cnt=%0d halted=%b want 0 0", run_cnt, halted); end
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_cmp++;
            if (dom_rst !== exp_dom()) begin n_bad++; $display("FAIL soft_seq: cycle %0d got %b want %b", k, dom_rst, exp_dom()); end
            if (f0 < 0 && dom_rst[0] === 1'b0) f0 = k;
            if (f1 < 0 && dom_rst[1] === 1'b0) f1 = k;
        end
        n_cmp++; if (f0 !== HOLD_CYC || f1 !== HOLD_CYC + STAGGER) begin n_bad++; $display("FAIL soft_release: got %0d/%0d want %0d/%0d", f0, f1, HOLD_CYC, HOLD_CYC + STAGGER); end
    endtask

    task automatic test_soft_vs_limit();
        for (int k = 0; k < 60 && run_cnt !== RUN_LIMIT; k++) tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL prio_halted: got %b want 0", halted); end
        n_cmp++; if (rst_cause !== 2'b01 || dom_rst !== 2'b11) begin n_bad++; $display("FAIL prio_soft: got cause=%b dom=%b want 01 11", rst_cause, dom_rst); end
        repeat (4) tick();
        #3 rst = 1'b0;
        #1 model_rst();
        n_cmp++; if (rst_cause !== 2'b00) begin n_bad++; $display("FAIL async_cause: got %b want 00", rst_cause); end
        n_cmp++; if (dom_rst !== 2'b11 || clk_en !== 1'b1 || run_cnt !== '0 || halted !== 1'b0) begin
            n_bad++; $display("FAIL async_outs: got dom=%b en=%b cnt=%0d halted=%b", dom_rst, clk_en, run_cnt, halted);
        end
        #3 rst = 1'b1;
    endtask

    task automatic test_wdt();
        int n = 0;
        wdt_kick = 1'b0;
        for (int k = 0; k < 60 && dom_rst !== '0; k++) tick();
        for (int k = 0; k < 60 && dom_rst[0] !== 1'b1; k++) begin tick(); n++; end
        n_cmp++; if (n !== WDT_CYC + 1) begin n_bad++; $display("FAIL wdt_timeout: got %0d cycles want %0d", n, WDT_CYC + 1); end
        n_cmp++; if (rst_cause !== 2'b10) begin n_bad++; $display("FAIL wdt_cause: got %b want 10", rst_cause); end
        for (int k = 0; k < 60 && dom_rst !== '0; k++) tick();
        for (int k = 1; k <= 30; k++) begin
            wdt_kick = (k % 10 == 0);
            tick();
            n_cmp++;
            if (dom_rst !== '0) begin n_bad++; $display("FAIL wdt_kicked: cycle %0d got %b want 00", k, dom_rst); end
        end
        wdt_kick = 1'b0;
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL wdt_kick_halt: got %b want 1", halted); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            soft_rst_req = ($urandom_range(0, 79) == 0);
            resume       = ($urandom_range(0, 7) == 0);
            wdt_kick     = ($urandom_range(0, 5) == 0);
            tick();
            n_cmp++;
            if (dom_rst !== exp_dom() || clk_en !== (m_mode != M_HALT) || halted !== (m_mode == M_HALT)
                || run_cnt !== CNT_W'(m_runs) || rst_cause !== 2'(m_cause)) begin
                n_bad++;
                $display("FAIL rand_cycle %0d: got dom=%b en=%b halt=%b cnt=%0d cause=%0d want dom=%b en=%b halt=%b cnt=%0d cause=%0d",
                         k, dom_rst, clk_en, halted, run_cnt, rst_cause,
                         exp_dom(), m_mode != M_HALT, m_mode == M_HALT, m_runs, m_cause);
            end
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                #2 model_rst();
                n_cmp++;
                if (dom_rst !== exp_dom() || run_cnt !== '0) begin n_bad++; $display("FAIL rand_async: got dom=%b cnt=%0d want %b 0", dom_rst, run_cnt, exp_dom()); end
                #2 rst = 1'b1;
            end
        end
        soft_rst_req = 1'b0;
        resume = 1'b0;
        wdt_kick = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_por();
        test_run_limit();
        test_resume();
        test_soft_rst();
        test_soft_vs_limit();
        if (WDT_ON) test_wdt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
